// File: rtl/sr_icache_ctrl_pkg.sv
// Shared types and defaults for the schoolRISCV instruction-cache controller.
package sr_icache_ctrl_pkg;

   localparam int unsigned ICS_ADDR_W     = 32;
   localparam int unsigned ICS_DATA_W     = 32;
   localparam int unsigned ICS_LINE_WORDS = 4;
   localparam int unsigned ICS_LINES      = 16;

   typedef enum logic [1:0] {
      ICS_IDLE   = 2'd0,
      ICS_LOOKUP = 2'd1,
      ICS_REFILL = 2'd2
   } ics_state_e;

   // Word address of the first word of the line containing a.
   function automatic logic [ICS_ADDR_W-1:0] line_base(input logic [ICS_ADDR_W-1:0] a,
                                                       input int unsigned off_w);
      return (a >> off_w) << off_w;
   endfunction

endpackage

// File: rtl/sr_icache_array.sv
// Tag/valid/data storage: combinational read, synchronous word write, tag set and clear-all.
module sr_icache_array
   import sr_icache_ctrl_pkg::*;
#(
   parameter  int unsigned LINE_WORDS = ICS_LINE_WORDS,
   parameter  int unsigned LINES      = ICS_LINES,
   localparam int unsigned OFF_W      = $clog2(LINE_WORDS),
   localparam int unsigned IDX_W      = $clog2(LINES),
   localparam int unsigned TAG_W      = ICS_ADDR_W - OFF_W - IDX_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IDX_W-1:0]      rd_idx_i,
   input  logic [OFF_W-1:0]      rd_off_i,
   output logic                  rd_valid_c_o,
   output logic [TAG_W-1:0]      rd_tag_c_o,
   output logic [ICS_DATA_W-1:0] rd_data_c_o,
   input  logic                  wr_en_i,
   input  logic [IDX_W-1:0]      wr_idx_i,
   input  logic [OFF_W-1:0]      wr_off_i,
   input  logic [ICS_DATA_W-1:0] wr_data_i,
   input  logic                  tag_set_i,
   input  logic [IDX_W-1:0]      tag_idx_i,
   input  logic [TAG_W-1:0]      tag_i,
   input  logic                  clr_i
);

   logic [LINES-1:0]      valid_q;
   logic [TAG_W-1:0]      tag_q  [LINES];
   logic [ICS_DATA_W-1:0] data_q [LINES][LINE_WORDS];

   assign rd_valid_c_o = valid_q[rd_idx_i];
   assign rd_tag_c_o   = tag_q[rd_idx_i];
   assign rd_data_c_o  = data_q[rd_idx_i][rd_off_i];

   // Clear-all wins over a tag set so a flush can never leave a line behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (clr_i) begin
         valid_q <= '0;
      end else if (tag_set_i) begin
         valid_q[tag_idx_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_set_i) begin
         tag_q[tag_idx_i] <= tag_i;
      end
      if (wr_en_i) begin
         data_q[wr_idx_i][wr_off_i] <= wr_data_i;
      end
   end

endmodule

// File: rtl/sr_icache_ctrl.sv
// Direct-mapped I-cache controller: lookup, burst line refill with replay, flush and hit/miss counters.
module sr_icache_ctrl
   import sr_icache_ctrl_pkg::*;
#(
   parameter int unsigned LINE_WORDS = ICS_LINE_WORDS,
   parameter int unsigned LINES      = ICS_LINES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  im_req,
   input  logic [ICS_ADDR_W-1:0] im_addr,
   output logic [ICS_DATA_W-1:0] im_data,
   output logic                  im_drdy,
   output logic                  mem_req,
   output logic [ICS_ADDR_W-1:0] mem_addr,
   input  logic [ICS_DATA_W-1:0] mem_rdata,
   input  logic                  mem_rvalid,
   input  logic                  flush,
   output logic [31:0]           hit_cnt,
   output logic [31:0]           miss_cnt
);

   localparam int unsigned OFF_W = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned TAG_W = ICS_ADDR_W - OFF_W - IDX_W;

   ics_state_e            state_q;
   logic [ICS_ADDR_W-1:0] req_addr_q;
   logic [OFF_W-1:0]      beat_cnt_q;
   logic                  flush_pend_q;
   logic                  replay_q;
   logic                  mem_req_q;
   logic [ICS_ADDR_W-1:0] mem_addr_q;
   logic [31:0]           hit_cnt_q;
   logic [31:0]           miss_cnt_q;

   logic [OFF_W-1:0]      req_off_c;
   logic [IDX_W-1:0]      req_idx_c;
   logic [TAG_W-1:0]      req_tag_c;
   logic                  line_valid_c;
   logic [TAG_W-1:0]      line_tag_c;
   logic [ICS_DATA_W-1:0] line_data_c;

   logic lookup_c, hit_c, miss_c, accept_c, beat_c, last_beat_c, clr_c;

   assign req_off_c = req_addr_q[OFF_W-1:0];
   assign req_idx_c = req_addr_q[OFF_W+IDX_W-1:OFF_W];
   assign req_tag_c = req_addr_q[ICS_ADDR_W-1:OFF_W+IDX_W];

   // Lookup decode; a pending flush is released in the replay lookup after the replay reads.
   always_comb begin
      lookup_c    = 1'b0;
      hit_c       = 1'b0;
      miss_c      = 1'b0;
      accept_c    = 1'b0;
      beat_c      = 1'b0;
      last_beat_c = 1'b0;
      clr_c       = 1'b0;
      lookup_c    = (state_q == ICS_LOOKUP);
      hit_c       = lookup_c && line_valid_c && (line_tag_c == req_tag_c);
      miss_c      = lookup_c && !hit_c;
      accept_c    = im_req && ((state_q == ICS_IDLE) || hit_c);
      beat_c      = (state_q == ICS_REFILL) && mem_rvalid;
      last_beat_c = beat_c && (beat_cnt_q == OFF_W'(LINE_WORDS - 1));
      clr_c       = (flush && (state_q != ICS_REFILL)) || (lookup_c && flush_pend_q);
   end

   assign im_drdy  = hit_c;
   assign im_data  = hit_c ? line_data_c : '0;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ICS_IDLE;
         req_addr_q   <= '0;
         beat_cnt_q   <= '0;
         flush_pend_q <= 1'b0;
         replay_q     <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         mem_req_q <= 1'b0;
         if (accept_c) begin
            req_addr_q <= im_addr;
         end
         if (hit_c && !replay_q) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (miss_c) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
         unique case (state_q)
            ICS_IDLE: begin
               if (accept_c) begin
                  state_q <= ICS_LOOKUP;
               end
            end
            ICS_LOOKUP: begin
               replay_q     <= 1'b0;
               flush_pend_q <= 1'b0;
               if (hit_c) begin
                  state_q <= accept_c ? ICS_LOOKUP : ICS_IDLE;
               end else begin
                  state_q    <= ICS_REFILL;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= line_base(req_addr_q, OFF_W);
                  beat_cnt_q <= '0;
               end
            end
            ICS_REFILL: begin
               if (flush) begin
                  flush_pend_q <= 1'b1;
               end
               if (beat_c) begin
                  beat_cnt_q <= beat_cnt_q + OFF_W'(1);
                  if (last_beat_c) begin
                     state_q    <= ICS_LOOKUP;
                     replay_q   <= 1'b1;
                     mem_addr_q <= '0;
                  end
               end
            end
            default: state_q <= ICS_IDLE;
         endcase
      end
   end

   sr_icache_array #(
      .LINE_WORDS (LINE_WORDS),
      .LINES      (LINES)
   ) u_array (
      .clk          (clk),
      .rst          (rst),
      .rd_idx_i     (req_idx_c),
      .rd_off_i     (req_off_c),
      .rd_valid_c_o (line_valid_c),
      .rd_tag_c_o   (line_tag_c),
      .rd_data_c_o  (line_data_c),
      .wr_en_i      (beat_c),
      .wr_idx_i     (req_idx_c),
      .wr_off_i     (beat_cnt_q),
      .wr_data_i    (mem_rdata),
      .tag_set_i    (last_beat_c),
      .tag_idx_i    (req_idx_c),
      .tag_i        (req_tag_c),
      .clr_i        (clr_c)
   );

endmodule

// File: tb/tb_sr_icache_ctrl.sv
// Scoreboard bench for sr_icache_ctrl: directed plan scenarios followed by randomized fetch traffic.
module tb_sr_icache_ctrl;

   localparam int unsigned LW    = 4;
   localparam int unsigned LN    = 16;
   localparam int unsigned OFF_W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        im_req;
   logic [31:0] im_addr;
   logic [31:0] im_data;
   logic        im_drdy;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        flush;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   always #5 clk = ~clk;

   sr_icache_ctrl #(.LINE_WORDS(LW), .LINES(LN)) dut (
      .clk        (clk),
      .rst        (rst),
      .im_req     (im_req),
      .im_addr    (im_addr),
      .im_data    (im_data),
      .im_drdy    (im_drdy),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .flush      (flush),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference cache: which line number each index currently holds.
   bit          mvalid [LN];
   logic [31:0] mline  [LN];
   bit          pend_clr;
   logic [31:0] exp_hit, exp_miss;
   logic [31:0] exp_q [$];

   logic [31:0] req_q [$];
   bit          outstanding, cur_miss, exp_refill, busy, force_flush;
   logic [31:0] cur_base;
   int          beats, gap, gap_lo, gap_hi, flush_mid_pct, flush_idle_pct, stale;
   int          cyc, issue_cyc, last_beat_cyc, wait_cyc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < int'(LN); i++) mvalid[i] = 1'b0;
      pend_clr = 1'b0;
   endtask

   task automatic issue(input logic [31:0] a);
      logic [31:0] line;
      int          idx;
      if (pend_clr) model_clear();
      line = a >> OFF_W;
      idx  = int'(line % LN);
      if (mvalid[idx] && mline[idx] == line) begin
         exp_hit  = exp_hit + 32'd1;
         cur_miss = 1'b0;
      end else begin
         exp_miss   = exp_miss + 32'd1;
         mvalid[idx] = 1'b1;
         mline[idx]  = line;
         cur_miss    = 1'b1;
         exp_refill  = 1'b1;
         cur_base    = line << OFF_W;
      end
      exp_q.push_back(mem_word(a));
      im_req      = 1'b1;
      im_addr     = a;
      outstanding = 1'b1;
      issue_cyc   = cyc;
      wait_cyc    = 0;
   endtask

   // One clock of memory responder plus core-side driver.
   task automatic cycle();
      bit in_refill, was_out;
      @(posedge clk);
      #1;
      cyc++;
      im_req     = 1'b0;
      flush      = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      in_refill  = busy || mem_req;
      if (mem_req) begin
         chk("mem_req_expected", 32'(mem_req), 32'(exp_refill));
         chk("mem_addr", mem_addr, cur_base);
         exp_refill = 1'b0;
         busy       = 1'b1;
         beats      = 0;
         gap        = int'($urandom_range(gap_hi, gap_lo));
      end else if (busy) begin
         chk("mem_addr_hold", mem_addr, cur_base);
         if (gap > 0) begin
            gap--;
         end else begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(cur_base + 32'(beats));
            beats++;
            gap = int'($urandom_range(gap_hi, gap_lo));
            if (beats == int'(LW)) begin
               busy          = 1'b0;
               last_beat_cyc = cyc;
            end
         end
      end else if (stale > 0) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hDEAD_BEEF;
         stale--;
      end
      if (in_refill && int'($urandom_range(99, 0)) < flush_mid_pct) begin
         flush    = 1'b1;
         pend_clr = 1'b1;
      end
      was_out = outstanding;
      if (!was_out) begin
         chk("hit_cnt", hit_cnt, exp_hit);
         chk("miss_cnt", miss_cnt, exp_miss);
         chk("mem_addr_idle", mem_addr, 32'd0);
      end
      if (outstanding && im_drdy) begin
         chk("drdy_latency", 32'(cyc), 32'(cur_miss ? last_beat_cyc + 1 : issue_cyc + 1));
         outstanding = 1'b0;
      end
      if (!outstanding) begin
         if (req_q.size() > 0 && stale == 0) begin
            issue(req_q.pop_front());
         end else if (!in_refill && (force_flush || int'($urandom_range(99, 0)) < flush_idle_pct)) begin
            flush       = 1'b1;
            force_flush = 1'b0;
            model_clear();
         end
      end else begin
         wait_cyc++;
         if (wait_cyc > 300) begin
            chk("fetch_timeout", 32'(wait_cyc), 32'd300);
            outstanding = 1'b0;
            exp_q.delete();
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((req_q.size() > 0 || outstanding || busy || stale > 0 || force_flush) && n < 5000) begin
         cycle();
         n++;
      end
      if (n >= 5000) chk("drain_timeout", 32'(n), 32'd0);
      cycle();
      cycle();
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      im_req = 1'b0;
      flush  = 1'b0;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_drdy", 32'(im_drdy), 32'd0);
      chk("rst_data", im_data, 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_hit_cnt", hit_cnt, 32'd0);
      chk("rst_miss_cnt", miss_cnt, 32'd0);
      model_clear();
      exp_hit     = '0;
      exp_miss    = '0;
      exp_q.delete();
      outstanding = 1'b0;
      exp_refill  = 1'b0;
      busy        = 1'b0;
      rst         = 1'b0;
   endtask

   // Monitor: every presented word is checked against the oldest expected word.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (im_drdy) begin
               if (exp_q.size() == 0) chk("drdy_unexpected", 32'(im_drdy), 32'd0);
               else chk("im_data", im_data, exp_q.pop_front());
            end else begin
               chk("im_data_idle_zero", im_data, 32'd0);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      im_req = 1'b0; im_addr = '0; mem_rdata = '0; mem_rvalid = 1'b0; flush = 1'b0;
      cyc = 0; stale = 0; force_flush = 1'b0; cur_miss = 1'b0; cur_base = '0;
      beats = 0; gap = 0; issue_cyc = 0; last_beat_cyc = 0; wait_cyc = 0;
      gap_lo = 0; gap_hi = 0; flush_mid_pct = 0; flush_idle_pct = 0;
      do_reset();

      // Cold miss right after reset, then back-to-back hits, then a conflict pair.
      req_q.push_back(32'h12); drain();
      req_q.push_back(32'h10); req_q.push_back(32'h11); req_q.push_back(32'h13); drain();
      req_q.push_back(32'h50); drain();
      req_q.push_back(32'h10); drain();

      // Gapped beats.
      gap_lo = 2; gap_hi = 2;
      req_q.push_back(32'h21); drain();
      gap_lo = 0; gap_hi = 0;

      // Flush in IDLE, then flush during a refill.
      force_flush = 1'b1; drain();
      req_q.push_back(32'h10); drain();
      flush_mid_pct = 100;
      req_q.push_back(32'h32); drain();
      flush_mid_pct = 0;
      req_q.push_back(32'h33); drain();

      // Reset after two beats, stale beats afterwards, then the same fetch again.
      force_flush = 1'b1; drain();
      req_q.push_back(32'h12);
      n = 0;
      while (!(busy && beats == 2) && n < 200) begin cycle(); n++; end
      if (n >= 200) chk("reset_setup_timeout", 32'(n), 32'd0);
      do_reset();
      stale = 2; drain();
      req_q.push_back(32'h12); drain();

      // Randomized traffic.
      gap_lo = 0; gap_hi = 3; flush_mid_pct = 4; flush_idle_pct = 5;
      for (int k = 0; k < 60; k++) begin
         int burst = int'($urandom_range(6, 1));
         for (int j = 0; j < burst; j++) req_q.push_back(32'($urandom_range(255, 0)));
         drain();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
